rr_grant_sequencer: RTL
=======================

Name: rr_grant_sequencer

Overview:
- 8-requester round-robin arbiter that time-shares one resource selected through the team's 3-to-8 one-hot decoder.
- Grant index is registered; the decoder stage turns it into the one-hot grant vector.
- Adds hold-until-release, a hold-time watchdog, and a one-cycle break-before-make gap between owners.
- Sits between requesting agents and the shared resource's select lines.

Parameters:
- MAX_HOLD, 16, maximum cycles one owner may keep the grant before forced release (legal range 1..255).
- CNT_W, 8, hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  request vector; bit i = requester i.
- done  input  1  owner releases the resource; sampled only in GRANT.
- gnt  output  8  one-hot grant; decoded from gnt_idx when gnt_valid=1, else 8'h00.
- gnt_idx  output  3  index of current owner.
- gnt_valid  output  1  grant active.
- timeout  output  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset values:
  - state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - last-granted pointer ptr=3'd7, so requester 0 wins first; hold counter=0.
- Reset is asynchronous. Asserting it mid-grant drops gnt/gnt_valid immediately, not at the next edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, search indices ptr+1, ptr+2, ... (mod 8) and take the first set bit.
  - At the next edge: gnt_idx=winner, ptr=winner, gnt_valid=1, counter=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - If req == 0, stay in IDLE.
- GRANT:
  - Each cycle, counter increments (saturating at MAX_HOLD).
  - Release conditions, any of:
    - done=1;
    - req[gnt_idx]=0;
    - counter == MAX_HOLD-1, i.e. the grant has been held for MAX_HOLD cycles.
  - On release, at the next edge: gnt_valid=0, state=GAP.
  - If the watchdog condition fired and neither done nor a req drop was present that cycle, timeout=1 for exactly the GAP cycle.
  - If done and the watchdog fire in the same cycle, done wins: no timeout pulse.
- GAP:
  - Exactly one cycle with gnt=8'h00.
  - Next state is IDLE.
  - No grant may appear in GAP (break-before-make).
- Fairness:
  - The just-released owner has the lowest priority in the next arbitration.
  - A requester that re-asserts after release waits behind all other active requesters.
- Wrap-around: ptr=7 searches 0,1,...,7; ptr=3 searches 4,5,6,7,0,1,2,3.
- Requests appearing or dropping during GRANT/GAP do not disturb the current owner; they are evaluated only in IDLE.
- gnt is a pure function of registered gnt_idx and gnt_valid, so it is glitch-free relative to clk.
- A single requester held continuously gets the pattern: grant, gap, idle, grant. This gives a 3-cycle period when done pulses every grant.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, GRANT=2'd1, GAP=2'd2), the requester count constant 8, and the index width 3.
- Sub-module: onehot_dec3to8, a combinational 3-bit to 8-bit one-hot decode with an enable input, instantiated for gnt.
- Everything else stays in rr_grant_sequencer: the priority search, FSM and watchdog counter.

Test Plan:
- Reset then req=8'hFF, done pulsed each GRANT cycle -> gnt sequence 01,02,04,08,10,20,40,80,01, each separated by GAP/IDLE cycles of 8'h00.
- req=8'b1000_0001 with ptr=7 after reset, done pulsed -> grant 0 first, then 7, then 0; never two consecutive grants to the same index while both request.
- req=8'h04 held, done never asserted, MAX_HOLD=16 -> gnt=8'h04 for exactly 16 cycles; timeout=1 for one cycle; then 8'h00 for 2 cycles, then regrant 8'h04.
- Owner 5 granted, req[5] dropped at hold cycle 3 -> gnt falls to 8'h00 at the next edge, timeout stays 0; the next requester (e.g. req[2]) is granted after the IDLE cycle.
- rst asserted asynchronously between edges while gnt=8'h10 -> gnt=8'h00 and gnt_valid=0 immediately. After release with req=8'hFF, the first grant is 8'h01.
- done and watchdog expiry in the same cycle -> release with timeout=0; GAP observed; arbitration resumes from ptr+1.

Source files
------------

// File: rtl/rr_grant_sequencer_pkg.sv
// Shared types, constants and the rotating priority search for the
// round-robin grant sequencer.
package rr_grant_sequencer_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walks from the farthest candidate (ptr itself) back to ptr+1, so the
    // requester nearest after ptr is written last and wins.
    function automatic pick_t rr_search(input logic [NUM_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   ptr);
        pick_t            pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesting agents (master) and the
// arbiter (slave).
interface rr_grant_sequencer_if;
    import rr_grant_sequencer_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/rr_grant_sequencer_onehot_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; all zeros when disabled.
module onehot_dec3to8 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    always_comb begin
        // NOTE: assign a default before any conditional write, otherwise a
        // path that skips the assignment infers a latch.
        onehot = 8'h00;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Eight-way round-robin arbiter with hold-until-release, hold-time watchdog
// and a one-cycle break-before-make gap between owners.
module rr_grant_sequencer
    import rr_grant_sequencer_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_grant_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);

    state_t             state_q,     state_d;
    logic [IDX_W-1:0]   ptr_q,       ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q,   gnt_idx_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q,   timeout_d;
    logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;

    pick_t              pick;
    logic               owner_req;
    logic               wd_fire;
    logic [NUM_REQ-1:0] gnt_vec;

    always_comb begin
        pick      = rr_search(bus.req, ptr_q);
        owner_req = bus.req[gnt_idx_q];
        wd_fire   = (hold_cnt_q == HOLD_LAST);

        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    gnt_idx_d   = pick.idx;
                    ptr_d       = pick.idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
                if (bus.done || !owner_req || wd_fire) begin
                    gnt_valid_d = 1'b0;
                    state_d     = GAP;
                    // A voluntary release in the same cycle masks the watchdog.
                    timeout_d   = wd_fire && !bus.done && owner_req;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    onehot_dec3to8 u_dec (
        .idx    (gnt_idx_q),
        .en     (gnt_valid_q),
        .onehot (gnt_vec)
    );

    assign bus.gnt       = gnt_vec;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule
